regfile_sb: RTL and testbench

Parametrised next-generation CPU register file with two write ports and a per-register pending scoreboard.
- Write port 0: single-cycle ALU writeback.
- Write port 1: long-latency writeback (load/multiply). It clears the pending bit of its destination.
- Sits between decode and writeback. Gives two combinational read ports plus a hazard stall signal for in-order issue.

---
 rtl/regfile_sb.sv | 85 ++++++++
 tb/tb_regfile_sb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: dual-write-port register file with a pending-write scoreboard and issue stall.
// Build option: define REGFILE_BYPASS_EN for same-cycle forwarding and a stall mask on port-1 clears.
module regfile_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter bit ZERO_REG = 1
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic              RsUsed,
  input  logic              RtUsed,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic              RegWre0,
  input  logic [ADDR_W-1:0] WriteReg0,
  input  logic [DATA_W-1:0] WriteData0,
  input  logic              RegWre1,
  input  logic [ADDR_W-1:0] WriteReg1,
  input  logic [DATA_W-1:0] WriteData1,
  input  logic              IssueValid,
  input  logic [ADDR_W-1:0] IssueReg,
  output logic              Stall,
  output logic [ADDR_W:0]   PendingCount
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(DEPTH - 1);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic              setEn, clrEn, incEn;

  function automatic logic isZero(input logic [ADDR_W-1:0] a);
    return ZERO_REG && a == '0;
  endfunction

  function automatic logic busy(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_BYPASS_EN
    return !isZero(a) && pending[a] && !(RegWre1 && WriteReg1 == a);
`else
    return !isZero(a) && pending[a];
`endif
  endfunction

  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_BYPASS_EN
    return isZero(a) ? '0 :
           (RegWre0 && WriteReg0 == a) ? WriteData0 :
           (RegWre1 && WriteReg1 == a) ? WriteData1 : regs[a];
`else
    return isZero(a) ? '0 : regs[a];
`endif
  endfunction

  assign ReadData1 = rd(rs);
  assign ReadData2 = rd(rt);
  assign Stall = (RsUsed && busy(rs)) || (RtUsed && busy(rt)) || (IssueValid && busy(IssueReg));

  // A same-cycle issue to the register being cleared keeps it pending: the new producer owns it.
  assign setEn = IssueValid && !Stall && !isZero(IssueReg);
  assign clrEn = RegWre1 && pending[WriteReg1] && !(setEn && IssueReg == WriteReg1);
  assign incEn = setEn && !pending[IssueReg];

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (RegWre1 && !isZero(WriteReg1)) regs[WriteReg1] <= WriteData1;
      if (RegWre0 && !isZero(WriteReg0)) regs[WriteReg0] <= WriteData0;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      pending      <= '0;
      PendingCount <= '0;
    end else begin
      if (RegWre1) pending[WriteReg1] <= 1'b0;
      if (setEn) pending[IssueReg] <= 1'b1;
      if (incEn && !clrEn && PendingCount != MAX_CNT) PendingCount <= PendingCount + 1'b1;
      else if (clrEn && !incEn && PendingCount != '0) PendingCount <= PendingCount - 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: table vectors, directed corner sequences and random traffic against a scoreboard model.
module tb_regfile_sb;
  logic        CLK = 0, RST_n = 0;
  logic [3:0]  rs, rt, WriteReg0, WriteReg1, IssueReg;
  logic        RsUsed, RtUsed, RegWre0, RegWre1, IssueValid;
  logic [15:0] WriteData0, WriteData1, ReadData1, ReadData2;
  logic        Stall;
  logic [4:0]  PendingCount;

  regfile_sb dut (
    .CLK(CLK), .RST_n(RST_n), .rs(rs), .rt(rt), .RsUsed(RsUsed), .RtUsed(RtUsed),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .RegWre0(RegWre0), .WriteReg0(WriteReg0), .WriteData0(WriteData0),
    .RegWre1(RegWre1), .WriteReg1(WriteReg1), .WriteData1(WriteData1),
    .IssueValid(IssueValid), .IssueReg(IssueReg), .Stall(Stall), .PendingCount(PendingCount)
  );

  always #5 CLK = ~CLK;

  int nErr = 0, nChk = 0;
  logic [15:0] mMem [16];
  bit          mPend [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit mBusy(input int r);
    if (r == 0) return 0;
`ifdef REGFILE_BYPASS_EN
    return mPend[r] && !(RegWre1 && int'(WriteReg1) == r);
`else
    return mPend[r];
`endif
  endfunction

  function automatic logic [15:0] mRead(input int a);
    if (a == 0) return 16'h0;
`ifdef REGFILE_BYPASS_EN
    if (RegWre0 && int'(WriteReg0) == a) return WriteData0;
    if (RegWre1 && int'(WriteReg1) == a) return WriteData1;
`endif
    return mMem[a];
  endfunction

  function automatic bit mStall();
    return (RsUsed && mBusy(rs)) || (RtUsed && mBusy(rt)) || (IssueValid && mBusy(IssueReg));
  endfunction

  function automatic int mCnt();
    int c = 0;
    for (int i = 0; i < 16; i++) c += mPend[i];
    return c;
  endfunction

  task automatic mReset();
    for (int i = 0; i < 16; i++) begin mMem[i] = 0; mPend[i] = 0; end
  endtask

  task automatic idle();
    rs = 0; rt = 0; RsUsed = 0; RtUsed = 0;
    RegWre0 = 0; WriteReg0 = 0; WriteData0 = 0;
    RegWre1 = 0; WriteReg1 = 0; WriteData1 = 0;
    IssueValid = 0; IssueReg = 0;
  endtask

  // Compares combinational outputs, clocks once, applies the architectural rules, checks the count.
  task automatic tick();
    bit st;
    st = mStall();
    chk("model_rd1", ReadData1, mRead(rs));
    chk("model_rd2", ReadData2, mRead(rt));
    chk("model_stall", Stall, st);
    @(posedge CLK);
    if (RegWre1 && WriteReg1 != 0) mMem[WriteReg1] = WriteData1;
    if (RegWre0 && WriteReg0 != 0) mMem[WriteReg0] = WriteData0;
    if (RegWre1) mPend[WriteReg1] = 0;
    if (IssueValid && !st && IssueReg != 0) mPend[IssueReg] = 1;
    #1;
    chk("model_cnt", PendingCount, mCnt());
  endtask

  typedef struct {
    logic [3:0] rs, rt; logic ru, tu;
    logic we0; logic [3:0] wr0; logic [15:0] wd0;
    logic we1; logic [3:0] wr1; logic [15:0] wd1;
    logic iv; logic [3:0] ir;
    logic [15:0] eRd1, eRd2; logic eStall; logic [4:0] eCnt;
  } vec_t;
  vec_t vecs [11];

  initial begin
    int c0;
    idle();
    mReset();
    vecs[0]  = '{0, 0, 0, 0, 1, 5, 16'h1234, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0};
    vecs[1]  = '{5, 0, 0, 0, 1, 0, 16'hBEEF, 0, 0, 0, 0, 0, 16'h1234, 16'h0000, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 16'h0000, 16'h0000, 0, 1};
    vecs[3]  = '{7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1};
    vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 16'h0000, 16'h0000, 1, 1};
    vecs[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 16'h0000, 16'h0000, 0, 2};
    vecs[6]  = '{0, 9, 0, 1, 0, 0, 0, 0, 0, 0, 1, 3, 16'h0000, 16'h0000, 1, 2};
    vecs[7]  = '{5, 0, 0, 0, 0, 0, 0, 1, 7, 16'h00C3, 0, 0, 16'h1234, 16'h0000, 0, 1};
    vecs[8]  = '{7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00C3, 16'h0000, 0, 1};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 1, 2, 16'h2222, 0, 0, 16'h0000, 16'h0000, 0, 1};
    vecs[10] = '{0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h2222, 0, 1};

    #12 RST_n = 1;
    @(posedge CLK); #1;
    chk("rst_cnt", PendingCount, 0);
    chk("rst_rd1", ReadData1, 0);
    chk("rst_rd2", ReadData2, 0);
    chk("rst_stall", Stall, 0);

    foreach (vecs[i]) begin
      rs = vecs[i].rs; rt = vecs[i].rt; RsUsed = vecs[i].ru; RtUsed = vecs[i].tu;
      RegWre0 = vecs[i].we0; WriteReg0 = vecs[i].wr0; WriteData0 = vecs[i].wd0;
      RegWre1 = vecs[i].we1; WriteReg1 = vecs[i].wr1; WriteData1 = vecs[i].wd1;
      IssueValid = vecs[i].iv; IssueReg = vecs[i].ir;
      #2;
      chk($sformatf("vec%0d_rd1", i), ReadData1, vecs[i].eRd1);
      chk($sformatf("vec%0d_rd2", i), ReadData2, vecs[i].eRd2);
      chk($sformatf("vec%0d_stall", i), Stall, vecs[i].eStall);
      tick();
      chk($sformatf("vec%0d_cnt", i), PendingCount, vecs[i].eCnt);
    end

    // Dual write to a pending register: port 0 data stored, pending cleared by port 1.
    idle(); IssueValid = 1; IssueReg = 3; #2; tick();
    c0 = mCnt();
    idle(); RegWre0 = 1; WriteReg0 = 3; WriteData0 = 16'hAAAA;
    RegWre1 = 1; WriteReg1 = 3; WriteData1 = 16'h5555; #2; tick();
    chk("dual_cnt", PendingCount, c0 - 1);
    idle(); rs = 3; RsUsed = 1; #2;
    chk("dual_data", ReadData1, 16'hAAAA);
    chk("dual_nostall", Stall, 0);
    tick();

    // Port 1 writeback consumed by a stalled reader.
    idle(); IssueValid = 1; IssueReg = 11; #2; tick();
    idle(); rs = 11; RsUsed = 1; #2;
    chk("sb_stall", Stall, 1);
    tick();
    RegWre1 = 1; WriteReg1 = 11; WriteData1 = 16'h00C3; #2;
`ifdef REGFILE_BYPASS_EN
    chk("wb_stall", Stall, 0);
    chk("wb_fwd", ReadData1, 16'h00C3);
`else
    chk("wb_stall", Stall, 1);
    chk("wb_old", ReadData1, 16'h0000);
`endif
    tick();
    idle(); rs = 11; RsUsed = 1; #2;
    chk("wb_after_rd", ReadData1, 16'h00C3);
    chk("wb_after_stall", Stall, 0);
    tick();

    // Set/clear race on r4.
    idle(); IssueValid = 1; IssueReg = 4; #2; tick();
    c0 = mCnt();
    idle(); RegWre1 = 1; WriteReg1 = 4; WriteData1 = 16'h4444; IssueValid = 1; IssueReg = 4; #2; tick();
    idle(); rs = 4; RsUsed = 1; #2;
`ifdef REGFILE_BYPASS_EN
    chk("race_cnt", PendingCount, c0);
    chk("race_pend", Stall, 1);
`else
    chk("race_cnt", PendingCount, c0 - 1);
    chk("race_pend", Stall, 0);
`endif
    tick();

    // WAW block on r9 (still pending from the table).
    c0 = mCnt();
    idle(); IssueValid = 1; IssueReg = 9; #2;
    chk("waw_stall", Stall, 1);
    tick();
    chk("waw_cnt", PendingCount, c0);
    idle(); rt = 9; RtUsed = 1; #2;
    chk("waw_pend", Stall, 1);
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rs = 4'($urandom); rt = 4'($urandom);
      RsUsed = 1'($urandom); RtUsed = 1'($urandom);
      RegWre0 = ($urandom_range(0, 2) == 0); WriteReg0 = 4'($urandom); WriteData0 = 16'($urandom);
      RegWre1 = ($urandom_range(0, 2) == 0); WriteReg1 = 4'($urandom); WriteData1 = 16'($urandom);
      IssueValid = 1'($urandom); IssueReg = 4'($urandom);
      if (n % 7 == 0) begin WriteReg1 = IssueReg; RegWre1 = 1; end
      #2; tick();
    end

    // Asynchronous reset between edges with live pending state.
    idle(); IssueValid = 1; IssueReg = 12; #2; tick();
    IssueReg = 13; #2; tick();
    IssueReg = 14; RegWre0 = 1; WriteReg0 = 2; WriteData0 = 16'h1111; #2; tick();
    idle(); rs = 2; rt = 12; RtUsed = 1; #2;
    chk("pre_rst_rd", ReadData1, 16'h1111);
    chk("pre_rst_stall", Stall, 1);
    RST_n = 0; #1;
    mReset();
    chk("arst_cnt", PendingCount, 0);
    chk("arst_stall", Stall, 0);
    chk("arst_rd", ReadData1, 0);
    @(negedge CLK); RST_n = 1;
    @(posedge CLK); #1;
    idle(); #2; tick();

    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end
endmodule
